// File: rtl/module_reg_writer_pkg.sv
// Shared types and defaults for the display-register write controller.
//   state_t : write FSM states
//   op_t    : write operation selected by the accepted button press
//   BTN_*   : index of each button in the per-button vectors of the top
package pkg_reg_writer;

   typedef enum logic [1:0] {IDLE, WRITE, WAIT_REL} state_t;
   typedef enum logic {OP_LOAD, OP_INC} op_t;

   // 10 ms of stable level at the 10 MHz system clock
   localparam int DEBOUNCE_DEFAULT = 100000;
   localparam int SYNC_DEFAULT     = 2;

   localparam int BTN_LOAD = 0;
   localparam int BTN_INC  = 1;

endpackage

// File: rtl/module_reg_writer_debounce.sv
// module_debounce: synchronizer + counter debouncer for one push-button.
//   clk, rst_n : system clock, async active-low reset
//   raw_i      : raw asynchronous button level
//   stable_o   : debounced level (starts at 0 after reset)
//   rise_o     : one-cycle pulse, coincident with stable_o going 0 -> 1
// A button already held when reset releases never yields rise_o: the
// debouncer only arms once it has seen a genuine low sample.
module module_debounce
   import pkg_reg_writer::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   vld_pipe;   // marks when sync_q holds real samples
   logic [CNT_W-1:0]       cnt_q;
   logic                   armed_q;
   logic                   lvl;

   assign lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         vld_pipe <= '0;
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         stable_o <= 1'b0;
         rise_o   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
         vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
         rise_o   <= 1'b0;
         if (vld_pipe[SYNC_STAGES] && !lvl)
            armed_q <= 1'b1;
         if (lvl == stable_o) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            stable_o <= lvl;
            rise_o   <= lvl & armed_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/module_reg_writer.sv
// module_reg_writer: turns raw switches and two push-buttons into clean
// writes of a WIDTH-bit clock-enabled register.
//   clk, rst_n  : 10 MHz system clock, async active-low reset
//   sw_i        : raw slide switches (synchronized, not debounced)
//   btn_load_i  : press writes the switch value
//   btn_inc_i   : press writes current value + 1 (wraps)
//   wr_data_o   : register data, valid with wr_ce_o and held afterwards
//   wr_ce_o     : one-cycle write enable
//   busy_o      : high from accepted press until both buttons are released
module module_reg_writer
   import pkg_reg_writer::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_i,
   input  logic             btn_load_i,
   input  logic             btn_inc_i,
   output logic [WIDTH-1:0] wr_data_o,
   output logic             wr_ce_o,
   output logic             busy_o
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync_q;
   logic [WIDTH-1:0]                  sw_lvl;
   logic [1:0]                        btn_raw, btn_stable, btn_rise;
   state_t                            state_q;
   op_t                               op;

   assign btn_raw[BTN_LOAD] = btn_load_i;
   assign btn_raw[BTN_INC]  = btn_inc_i;
   assign sw_lvl            = sw_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sw_sync_q <= '0;
      else        sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw_i};
   end

   for (genvar b = 0; b < 2; b++) begin : g_btn
      module_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_db (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (btn_raw[b]),
         .stable_o (btn_stable[b]),
         .rise_o   (btn_rise[b])
      );
   end

   // Load has priority when both edges land in the same cycle
   always_comb op = btn_rise[BTN_LOAD] ? OP_LOAD : OP_INC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wr_data_o <= '0;
         wr_ce_o   <= 1'b0;
         busy_o    <= 1'b0;
      end else begin
         wr_ce_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|btn_rise) begin
                  state_q   <= WRITE;
                  wr_ce_o   <= 1'b1;
                  busy_o    <= 1'b1;
                  wr_data_o <= (op == OP_LOAD) ? sw_lvl : wr_data_o + 1'b1;
               end else if (|btn_stable) begin
                  // level came up without an armed edge (held through reset)
                  state_q <= WAIT_REL;
                  busy_o  <= 1'b1;
               end
            end
            WRITE:    state_q <= WAIT_REL;
            WAIT_REL: begin
               if (~|btn_stable) begin
                  state_q <= IDLE;
                  busy_o  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/module_reg_writer.md
Name: module_reg_writer

Overview:
- Write-side controller for the 4-bit clock-enabled display register (the register's data inputs and ce input).
- Turns raw board switches and two push-buttons into clean register writes: 4-bit write data plus a single-cycle write-enable pulse.
- Runs in the 10 MHz clock domain produced by the clock wizard and sits between the board I/O pins and the register/7-segment path.
- Replaces hand-driven ce/data stimulus with debounced, edge-qualified hardware writes.

Parameters:
- WIDTH, 4, data width of switches and write bus.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a new button level (10 ms at 10 MHz); benches override to 4.
- SYNC_STAGES, 2, synchronizer flip-flop depth on every raw input (minimum 2).

Ports:
- clk  in  1  10 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_i  in  WIDTH  raw slide switches (asynchronous).
- btn_load_i  in  1  raw push-button; press writes the switch value.
- btn_inc_i  in  1  raw push-button; press writes current value + 1.
- wr_data_o  out  WIDTH  write data to the register's data inputs.
- wr_ce_o  out  1  one-cycle write enable to the register's ce input.
- busy_o  out  1  high from accepted press until button release is debounced.

Behaviour:
- Reset (async assert, sync deassert through the synchronizers): wr_data_o=0, wr_ce_o=0, busy_o=0, FSM=IDLE, debounce counters=0, synchronizers=0.
- All raw inputs pass SYNC_STAGES flip-flops before use. Switches are synchronized only, not debounced; they are sampled on the write cycle.
- Per-button debouncer:
  - Counter resets whenever the synchronized level equals the current stable level.
  - The counter increments while the levels differ.
  - At DEBOUNCE_CYCLES-1 the stable level toggles and the counter clears.
- FSM states: IDLE, WRITE, WAIT_REL.
  - IDLE: on a stable rising edge of load go to WRITE with op=LOAD. Otherwise, on a stable rising edge of inc, go to WRITE with op=INC.
  - Simultaneous load and inc edges in the same cycle: load wins and inc is discarded.
  - WRITE, exactly one cycle:
    - wr_ce_o=1.
    - wr_data_o updates on entry to WRITE: LOAD puts the synchronized sw_i into wr_data_o. INC puts wr_data_o+1 mod 2^WIDTH into wr_data_o, so 4'hF wraps to 4'h0.
    - wr_data_o is valid in the same cycle wr_ce_o is high and holds afterwards.
    - Go to WAIT_REL.
  - WAIT_REL: stay until both debounced buttons are low, then return to IDLE. busy_o=1 in WRITE and WAIT_REL.
- Press latency: raw edge to wr_ce_o high = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (±1 for the synchronizer sampling phase).
- Exactly one wr_ce_o pulse per press regardless of press duration or bounce. Presses on either button during WAIT_REL are ignored and produce no write.
- A button held through reset produces no write after reset until it is released and pressed again. The debouncer starts with stable=0 and the FSM waits for both buttons low (enter WAIT_REL if either stable level is 1 when leaving IDLE check).
- Reset asserted mid-press or during WRITE: outputs go to reset values immediately. A partial write is never completed.
- Bounce shorter than DEBOUNCE_CYCLES on either edge produces no state change.

Decomposition:
- Shared package pkg_reg_writer:
  - typedef enum logic [1:0] {IDLE, WRITE, WAIT_REL} state_t.
  - typedef enum logic {OP_LOAD, OP_INC} op_t.
  - localparam for the default debounce count.
- One sub-module, module_debounce: synchronizer + counter debouncer + rising-edge pulse output. Parameters DEBOUNCE_CYCLES and SYNC_STAGES; ports clk, rst_n, raw_i, stable_o, rise_o.
- module_debounce is instantiated twice, one per button.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 100 MHz bench clock):
- Reset: hold rst_n=0 with buttons toggling -> wr_ce_o=0, wr_data_o=0, busy_o=0 throughout; release shows no write.
- Load: sw_i=4'b0101, clean load press of 20 cycles -> exactly one wr_ce_o pulse with wr_data_o=4'h5, within 7 cycles of the press; busy_o falls after release + debounce.
- Bounce: load toggled every 2 cycles for 12 cycles then held high -> exactly one write; toggles of 3 cycles or less after release produce no extra write.
- Increment and wrap: load 4'hE, then three inc presses -> wr_data_o sequence E, F, 0, 1; one ce pulse each.
- Simultaneous presses: load and inc asserted in the same cycle with sw_i=4'h3 and wr_data_o=4'h9 -> single write, wr_data_o=4'h3; a second press before both buttons are released produces no write.
- Reset mid-operation: assert rst_n=0 in the WRITE cycle -> wr_ce_o and wr_data_o drop to 0 asynchronously; a held button after reset produces no write until it is re-pressed.
